ysyx_24100027_ifu: RTL
======================

# ysyx_24100027_ifu

Instruction fetch unit for the ysyx_24100027 core. It owns the architectural PC. It issues word fetches to instruction memory over a valid/ready request channel and a valid-only response channel. Each fetched instruction is presented to the core's decode/execute stage as a (pc, inst) pair with a valid/ready handshake, and the next PC is taken back from the core on acceptance. The block is the producer of the `pc`/`inst` pair that the single-cycle CPU datapath consumes.

## Interface
- RESET_PC, 32'h8000_0000, PC loaded on reset.
- TIMEOUT, 255, response-wait limit in cycles (1..255). The wait counter is 8 bits.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  fetch address (= pc).
- imem_resp_valid  in  1  response data valid (single-cycle pulse).
- imem_resp_data  in  32  fetched instruction word.
- imem_resp_err  in  1  access fault, qualified by imem_resp_valid.
- inst_valid  out  1  pc/inst/fetch_err valid to the core.
- inst_ready  in  1  core consumes the instruction this cycle.
- pc  out  32  PC of the presented instruction.
- inst  out  32  presented instruction word.
- npc  in  32  next PC from the core, sampled on inst handshake.
- fetch_err  out  1  presented fetch faulted; inst is 0.
- fetch_cause  out  2  0 none, 1 misaligned, 2 access fault, 3 timeout.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- Reset (asynchronous, immediate) forces:
  - state = IDLE
  - pc = RESET_PC, inst = 0
  - fetch_err = 0, fetch_cause = 0
  - wait counter = 0
  - imem_req_valid = 0, inst_valid = 0
  - Any outstanding memory response is abandoned.
- IDLE: go to REQ on the next clock unconditionally.
- REQ:
  - If pc[1:0] != 0: no request is issued (imem_req_valid = 0). Set inst = 0, fetch_err = 1, fetch_cause = 1, and go to DONE.
  - Otherwise: imem_req_valid = 1 and imem_req_addr = pc. Both stay stable until imem_req_ready is sampled high. On acceptance, clear the counter and go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - On imem_resp_valid: inst = resp_err ? 0 : imem_resp_data, fetch_err = resp_err, fetch_cause = resp_err ? 2 : 0. Go to DONE.
  - If the counter reaches TIMEOUT with no response: inst = 0, fetch_err = 1, fetch_cause = 3. Go to DONE.
  - A response in the same cycle the counter hits TIMEOUT wins over the timeout.
- DONE:
  - inst_valid = 1; pc, inst, fetch_err and fetch_cause are held stable.
  - On inst_ready: pc <= npc, clear fetch_err/fetch_cause, go to REQ.
  - Faulted instructions complete the same way; the core supplies the trap target via npc.
- imem_resp_valid outside WAIT (late after timeout, or spurious) is ignored and changes no state.
- imem_resp_valid is never honoured in the cycle the request is accepted. Memory returns data at the earliest one cycle after acceptance.
- At most one request is outstanding; no prefetch.

## Timing
- All outputs are registered or decoded from state only. No combinational path from inst_ready, npc or imem_* inputs to any output.
- Zero-wait memory (ready high, response 1 cycle after acceptance):
  - cycle t: REQ accepted
  - cycle t+1: response
  - cycle t+2: inst_valid
  - cycle t+2: handshake, if inst_ready is high
  - cycle t+3: next REQ
  - Throughput: one instruction per 3 cycles after the first.
- First request is at the second rising edge after rst deasserts.
- Misaligned PC: REQ cycle, then inst_valid the next cycle, with no memory traffic.
- Timeout: inst_valid asserts TIMEOUT+1 cycles after request acceptance.
- inst_ready held low stalls indefinitely in DONE with outputs stable.
- imem_req_ready held low stalls in REQ with the address stable.

## Test plan
- Reset, then a zero-wait memory returning 0x00000413 at 0x80000000. Required:
  - first request addr 0x80000000 on the 2nd edge after reset release
  - pc=0x80000000, inst=0x00000413 with inst_valid
  - after npc=0x80000004 is accepted, the next request addr is 0x80000004
- Backpressure:
  - imem_req_ready low for 3 cycles: address held and no state change.
  - inst_ready low for 5 cycles: pc/inst unchanged, and exactly one request per instruction.
- npc=0x80000102 accepted -> no memory request; inst_valid with fetch_err=1, fetch_cause=1, inst=0, pc=0x80000102.
- Response with imem_resp_err=1 -> fetch_cause=2, inst=0. Then no response with TIMEOUT=4 -> fetch_cause=3 exactly 5 cycles after acceptance. A late response 2 cycles later is ignored.
- Reset asserted while in WAIT -> outputs return to reset values immediately. The pending response is dropped, and fetch restarts at 0x80000000.

Source files
------------

// File: rtl/ysyx_24100027_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word at a time from instruction memory
// and presents (pc, inst) to the core, reporting misaligned, access-fault and timeout errors.
module ysyx_24100027_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] pc,
  output logic [31:0] inst,
  input  logic [31:0] npc,
  output logic        fetch_err,
  output logic [1:0]  fetch_cause
);

  localparam logic [7:0] TimeoutCnt    = 8'(TIMEOUT);
  localparam logic [1:0] CauseNone     = 2'd0;
  localparam logic [1:0] CauseMisalign = 2'd1;
  localparam logic [1:0] CauseAccess   = 2'd2;
  localparam logic [1:0] CauseTimeout  = 2'd3;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        err_q, err_d;
  logic [1:0]  cause_q, cause_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;
  logic        pc_misaligned;

  assign cnt_inc       = cnt_q + 8'd1;
  assign pc_misaligned = (pc_q[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    err_d   = err_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (pc_misaligned) begin
          inst_d  = '0;
          err_d   = 1'b1;
          cause_d = CauseMisalign;
          state_d = StDone;
        end else if (imem_req_ready) begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_inc;
        // A response arriving on the timeout cycle still wins.
        if (imem_resp_valid) begin
          inst_d  = imem_resp_err ? 32'h0 : imem_resp_data;
          err_d   = imem_resp_err;
          cause_d = imem_resp_err ? CauseAccess : CauseNone;
          state_d = StDone;
        end else if (cnt_inc == TimeoutCnt) begin
          inst_d  = '0;
          err_d   = 1'b1;
          cause_d = CauseTimeout;
          state_d = StDone;
        end
      end
      StDone: begin
        if (inst_ready) begin
          pc_d    = npc;
          err_d   = 1'b0;
          cause_d = CauseNone;
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      err_q   <= 1'b0;
      cause_q <= CauseNone;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req_valid = (state_q == StReq) && !pc_misaligned;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == StDone);
  assign pc             = pc_q;
  assign inst           = inst_q;
  assign fetch_err      = err_q;
  assign fetch_cause    = cause_q;

endmodule
